// File: rtl/gruel_vend_ctrl.sv
// -----------------------------------------------------------------------------
// gruel_vend_ctrl
//
// Sequencing controller for the gruel vending datapath. Inserted coins are
// accumulated into a saturating shilling credit register. That register drives
// the 4-bit gruel decoder (X3..X0) directly, and the decoder qualifies the
// purchase. The block runs the dispense handshake and then pays any remaining
// credit back as change, one shilling per cycle.
//
// Optional feature macro: GRUEL_VEND_AUDIT_EN
//   When defined, the block adds output o_sales_count[15:0]. The counter
//   increments on each acknowledged dispense and wraps from 0xFFFF to 0.
//   When undefined, the port and the counter do not exist.
//
// Parameters:
//   PRICE       cost of one gruel in shillings (1 <= PRICE <= MAX_CREDIT)
//   MAX_CREDIT  largest credit the register may hold
//   CREDIT_W    width of the credit register and bus
//
// Ports:
//   i_clk            system clock, all state on rising edge
//   i_reset          synchronous, active-high reset
//   i_coin_valid     coin present this cycle
//   i_coin_val       coin code: 01=1, 10=2, 11=4 shillings, 00=invalid
//   i_buy            purchase request, sampled per cycle
//   i_cancel         refund request, sampled per cycle
//   i_dispense_ack   dispenser mechanism has taken the gruel
//   o_credit         current credit (registered), to decoder X3..X0
//   o_gruel_ok       credit >= PRICE (combinational from registered credit)
//   o_dispense       dispense request, held until acked
//   o_change_pulse   one shilling of change returned this cycle
//   o_coin_reject    one-cycle pulse: last coin returned to user
//   o_busy           high in DISPENSE or CHANGE
//   o_sales_count    (GRUEL_VEND_AUDIT_EN only) completed sales, wrapping
// -----------------------------------------------------------------------------
module gruel_vend_ctrl #(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 8,
  parameter int CREDIT_W   = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_coin_valid,
  input  logic [1:0]          i_coin_val,
  input  logic                i_buy,
  input  logic                i_cancel,
  input  logic                i_dispense_ack,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_gruel_ok,
  output logic                o_dispense,
  output logic                o_change_pulse,
  output logic                o_coin_reject,
  output logic                o_busy
`ifdef GRUEL_VEND_AUDIT_EN
  ,
  output logic [15:0]         o_sales_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,  // credit == 0
    S_COLLECT  = 2'd1,  // credit > 0
    S_DISPENSE = 2'd2,  // waiting for the dispenser to take the gruel
    S_CHANGE   = 2'd3   // paying credit back one shilling per cycle
  } state_t;

  // The coin sum is formed one bit wider than the register. Overflow is then
  // visible as a large value, and the sum never wraps to a small one.
  localparam logic [CREDIT_W:0]   PRICE_EXT  = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_EXT    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_CR   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

  // Registered state
  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic                r_change_pulse;
  logic                r_coin_reject;
  logic                r_busy;

  // Next-state values
  state_t              w_next_state;
  logic [CREDIT_W-1:0] w_next_credit;
  logic                w_next_dispense;
  logic                w_next_change_pulse;
  logic                w_next_coin_reject;
  logic                w_next_busy;

  // Decoded inputs
  logic [CREDIT_W:0]   w_coin_value;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_credit_zero;
  logic                w_accepting;     // IDLE or COLLECT: inputs are honoured
  logic                w_cancel_take;
  logic                w_buy_take;
  logic                w_coin_take;
  logic                w_sale;

  // Coin code to shilling value. Code 00 decodes to zero, and that zero
  // also marks the coin as invalid.
  always_comb begin
    w_coin_value = '0;
    unique case (i_coin_val)
      2'b01:   w_coin_value = (CREDIT_W+1)'(1);
      2'b10:   w_coin_value = (CREDIT_W+1)'(2);
      2'b11:   w_coin_value = (CREDIT_W+1)'(4);
      default: w_coin_value = '0;
    endcase
  end

  assign w_coin_sum    = {1'b0, r_credit} + w_coin_value;
  assign w_credit_zero = (r_credit == '0);
  assign w_accepting   = (r_state == S_IDLE) || (r_state == S_COLLECT);

  // Priority in IDLE/COLLECT: cancel, then buy, then coin. A cancel with
  // zero credit does nothing, but it still blocks a coin in the same cycle.
  // Such a coin is returned to the user.
  assign w_cancel_take = w_accepting && i_cancel && !w_credit_zero;
  assign w_buy_take    = w_accepting && i_buy && !i_cancel &&
                         ({1'b0, r_credit} >= PRICE_EXT);
  assign w_coin_take   = w_accepting && i_coin_valid && !i_cancel &&
                         !w_buy_take && (i_coin_val != 2'b00) &&
                         (w_coin_sum <= MAX_EXT);

  // A sale is counted at the moment the dispenser acknowledges the gruel.
  assign w_sale = (r_state == S_DISPENSE) && i_dispense_ack;

  // NOTE: every signal driven here gets a default before the case statement.
  // Without the defaults, any path that misses an assignment infers a latch.
  always_comb begin
    w_next_state        = r_state;
    w_next_credit       = r_credit;
    w_next_dispense     = r_dispense;
    w_next_change_pulse = 1'b0;
    // Any coin that is not taken, in any state, goes back to the user.
    w_next_coin_reject  = i_coin_valid && !w_coin_take;

    unique case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_cancel_take) begin
          w_next_state = S_CHANGE;
        end else if (w_buy_take) begin
          w_next_credit   = r_credit - PRICE_CR;
          w_next_dispense = 1'b1;
          w_next_state    = S_DISPENSE;
        end else if (w_coin_take) begin
          w_next_credit = w_coin_sum[CREDIT_W-1:0];
          w_next_state  = S_COLLECT;
        end
      end

      S_DISPENSE: begin
        // buy and cancel are ignored while the dispenser owns the cycle.
        if (i_dispense_ack) begin
          w_next_dispense = 1'b0;
          w_next_state    = w_credit_zero ? S_IDLE : S_CHANGE;
        end
      end

      S_CHANGE: begin
        // Pulse count equals the credit on entry. The pulse appears in the
        // same cycle as the decremented credit. When the credit has reached
        // zero, the next cycle has no pulse and the state returns to IDLE.
        if (!w_credit_zero) begin
          w_next_change_pulse = 1'b1;
          w_next_credit       = r_credit - CREDIT_ONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state    = S_IDLE;
        w_next_credit   = '0;
        w_next_dispense = 1'b0;
      end
    endcase

    // busy is registered together with the state, so the two move in step.
    w_next_busy = (w_next_state == S_DISPENSE) || (w_next_state == S_CHANGE);
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_dispense     <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_credit       <= w_next_credit;
      r_dispense     <= w_next_dispense;
      r_change_pulse <= w_next_change_pulse;
      r_coin_reject  <= w_next_coin_reject;
      r_busy         <= w_next_busy;
    end
  end

`ifdef GRUEL_VEND_AUDIT_EN
  logic [15:0] r_sales_count;

  // 16-bit counter that wraps from 0xFFFF to 0 by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sales_count <= '0;
    end else if (w_sale) begin
      r_sales_count <= r_sales_count + 16'd1;
    end
  end

  assign o_sales_count = r_sales_count;
`else
  // Without the audit counter, w_sale still exists but drives nothing.
  logic w_sale_unused;
  assign w_sale_unused = w_sale;
`endif

  assign o_credit       = r_credit;
  assign o_gruel_ok     = ({1'b0, r_credit} >= PRICE_EXT);
  assign o_dispense     = r_dispense;
  assign o_change_pulse = r_change_pulse;
  assign o_coin_reject  = r_coin_reject;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_gruel_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gruel_vend_ctrl
//
// Directed testbench for gruel_vend_ctrl, using the default parameters
// (PRICE=4, MAX_CREDIT=8, CREDIT_W=4). Inputs are driven 1 time unit after
// each rising edge. Outputs are checked at that same point, once the edge's
// register updates have settled. The expected values are worked out by hand.
// The audit counter checks are compiled in only when GRUEL_VEND_AUDIT_EN is
// defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gruel_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       buy;
  logic       cancel;
  logic       dispense_ack;
  logic [3:0] credit;
  logic       gruel_ok;
  logic       dispense;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;
`ifdef GRUEL_VEND_AUDIT_EN
  logic [15:0] sales_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gruel_vend_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_coin_valid   (coin_valid),
    .i_coin_val     (coin_val),
    .i_buy          (buy),
    .i_cancel       (cancel),
    .i_dispense_ack (dispense_ack),
    .o_credit       (credit),
    .o_gruel_ok     (gruel_ok),
    .o_dispense     (dispense),
    .o_change_pulse (change_pulse),
    .o_coin_reject  (coin_reject),
    .o_busy         (busy)
`ifdef GRUEL_VEND_AUDIT_EN
    ,
    .o_sales_count  (sales_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    cycle();
    coin_valid = 1'b0;
    coin_val   = 2'b00;
  endtask

  task automatic press_buy();
    buy = 1'b1;
    cycle();
    buy = 1'b0;
  endtask

  task automatic press_cancel();
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
  endtask

  task automatic ack();
    dispense_ack = 1'b1;
    cycle();
    dispense_ack = 1'b0;
  endtask

  // Called right after entry to CHANGE. Expects exactly n consecutive
  // pulses, the first one on the next cycle, and no dispense during them.
  // After the pulses the controller must be idle with zero credit.
  task automatic expect_refund(input string tag, input int n);
    int  pulses     = 0;
    bit  done       = 1'b0;
    bit  disp_seen  = 1'b0;
    bit  first_hit  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      if (i == 0) first_hit = change_pulse;
      if (dispense) disp_seen = 1'b1;
      if (change_pulse) pulses++;
      else if (pulses > 0) done = 1'b1;
    end
    check({tag, "_first_pulse"}, 32'(first_hit), 32'd1);
    check({tag, "_pulses"},      32'(pulses),    32'(n));
    check({tag, "_finished"},    32'(done),      32'd1);
    check({tag, "_no_dispense"}, 32'(disp_seen), 32'd0);
    check({tag, "_credit0"},     32'(credit),    32'd0);
    check({tag, "_idle"},        32'(busy),      32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_credit"},   32'(credit),       32'd0);
    check({tag, "_dispense"}, 32'(dispense),     32'd0);
    check({tag, "_change"},   32'(change_pulse), 32'd0);
    check({tag, "_reject"},   32'(coin_reject),  32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_ok"},       32'(gruel_ok),     32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    coin_valid   = 1'b0;
    coin_val     = 2'b00;
    buy          = 1'b0;
    cancel       = 1'b0;
    dispense_ack = 1'b0;
    cycle();
    cycle();
    check_reset_outputs("rst");
`ifdef GRUEL_VEND_AUDIT_EN
    check("rst_sales", 32'(sales_count), 32'd0);
`endif
    reset = 1'b0;

    // Test 1: 4 + 4, buy, ack on the third DISPENSE cycle, 4 shillings change.
    coin(2'b11);
    check("t1_credit4", 32'(credit), 32'd4);
    check("t1_ok4",     32'(gruel_ok), 32'd1);
    coin(2'b11);
    check("t1_credit8", 32'(credit), 32'd8);
    check("t1_ok8",     32'(gruel_ok), 32'd1);
    check("t1_nobusy",  32'(busy), 32'd0);
    press_buy();
    check("t1_dispense", 32'(dispense), 32'd1);
    check("t1_credit_after_buy", 32'(credit), 32'd4);
    check("t1_busy", 32'(busy), 32'd1);
    cycle();
    check("t1_hold1", 32'(dispense), 32'd1);
    cycle();
    check("t1_hold2", 32'(dispense), 32'd1);
    ack();
    check("t1_dispense_drop", 32'(dispense), 32'd0);
    check("t1_change_busy", 32'(busy), 32'd1);
    check("t1_change_credit", 32'(credit), 32'd4);
    expect_refund("t1", 4);

    // Test 2: credit 7, a 2-shilling coin would overflow; 1 fills to 8 exactly.
    coin(2'b11);
    coin(2'b10);
    coin(2'b01);
    check("t2_credit7", 32'(credit), 32'd7);
    coin(2'b10);
    check("t2_reject", 32'(coin_reject), 32'd1);
    check("t2_credit_kept", 32'(credit), 32'd7);
    coin(2'b01);
    check("t2_reject_clear", 32'(coin_reject), 32'd0);
    check("t2_credit8", 32'(credit), 32'd8);
    coin(2'b01);
    check("t2_full_reject", 32'(coin_reject), 32'd1);
    check("t2_full_credit", 32'(credit), 32'd8);
    press_cancel();
    check("t2_cancel_busy", 32'(busy), 32'd1);
    expect_refund("t2", 8);

    // Test 3: credit 3, buy ignored; invalid code 00 rejected.
    coin(2'b10);
    coin(2'b01);
    check("t3_credit3", 32'(credit), 32'd3);
    check("t3_ok3", 32'(gruel_ok), 32'd0);
    press_buy();
    check("t3_no_dispense", 32'(dispense), 32'd0);
    check("t3_no_busy", 32'(busy), 32'd0);
    check("t3_credit_kept", 32'(credit), 32'd3);
    coin(2'b00);
    check("t3_reject00", 32'(coin_reject), 32'd1);
    check("t3_credit_still3", 32'(credit), 32'd3);
    cycle();
    check("t3_reject_one_cycle", 32'(coin_reject), 32'd0);

    // Test 4: credit 5, buy and cancel together; cancel wins.
    coin(2'b10);
    check("t4_credit5", 32'(credit), 32'd5);
    buy    = 1'b1;
    cancel = 1'b1;
    cycle();
    buy    = 1'b0;
    cancel = 1'b0;
    check("t4_no_dispense", 32'(dispense), 32'd0);
    check("t4_credit5_kept", 32'(credit), 32'd5);
    expect_refund("t4", 5);

    // Test 5: credit 6, buy, coin in DISPENSE rejected, reset before ack.
    coin(2'b11);
    coin(2'b10);
    check("t5_credit6", 32'(credit), 32'd6);
    press_buy();
    check("t5_dispense", 32'(dispense), 32'd1);
    check("t5_credit2", 32'(credit), 32'd2);
    coin(2'b01);
    check("t5_reject", 32'(coin_reject), 32'd1);
    check("t5_credit2_kept", 32'(credit), 32'd2);
    check("t5_still_dispense", 32'(dispense), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_reset_outputs("t5_rst");
    cycle();
    check("t5_stays_idle", 32'(busy), 32'd0);

`ifdef GRUEL_VEND_AUDIT_EN
    // Audit: three purchases count, a cancel-only refund does not.
    for (int k = 0; k < 3; k++) begin
      coin(2'b11);
      press_buy();
      ack();
      check("aud_idle_after_sale", 32'(busy), 32'd0);
    end
    check("aud_sales3", 32'(sales_count), 32'd3);
    coin(2'b01);
    press_cancel();
    expect_refund("aud_refund", 1);
    check("aud_sales_unchanged", 32'(sales_count), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gruel_vend_ctrl.md
Name: gruel_vend_ctrl

Overview:
Sequencing controller for the gruel vending datapath.
- Accumulates inserted coins into a saturating shilling credit register.
- The credit bus drives the existing 4-bit gruel decoder (X3..X0), so the decoder qualifies the purchase.
- Runs the dispense handshake, then pays remaining credit back as change, one shilling per cycle.

Parameters:
PRICE, 4, cost of one gruel in shillings; must satisfy 1 <= PRICE <= MAX_CREDIT.
MAX_CREDIT, 8, maximum credit held; must fit in CREDIT_W bits.
CREDIT_W, 4, width of the credit register and bus.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
coin_valid  input  1  coin present this cycle
coin_val  input  2  coin code: 01=1 shilling, 10=2, 11=4, 00=invalid
buy  input  1  purchase request, sampled per cycle
cancel  input  1  refund request, sampled per cycle
dispense_ack  input  1  dispenser mechanism has taken the gruel
credit  output  CREDIT_W  current credit (registered), to decoder X3..X0
gruel_ok  output  1  credit >= PRICE (combinational from registered credit)
dispense  output  1  dispense request, held until acked
change_pulse  output  1  one shilling of change returned this cycle
coin_reject  output  1  one-cycle pulse: last coin returned to user
busy  output  1  high in DISPENSE or CHANGE

Behaviour:
- Reset values: state=IDLE, credit=0, dispense=0, change_pulse=0, coin_reject=0, busy=0. Audit count=0 when the optional feature is enabled.
- Reset mid-operation aborts any dispense or change sequence immediately. Credit is lost; no change is paid.
- States: IDLE (credit=0), COLLECT (credit>0), DISPENSE, CHANGE.
- Per-cycle priority in IDLE/COLLECT, highest first:
  - 1. cancel
  - 2. buy
  - 3. coin
- cancel with credit>0: go to CHANGE. cancel with credit=0: ignored.
- buy with credit>=PRICE:
  - credit <= credit-PRICE, dispense <= 1, go to DISPENSE.
  - buy with credit<PRICE is ignored; no state change.
- Coin accepted only if all hold:
  - no cancel or accepted buy in the same cycle;
  - coin_val != 00;
  - credit + value <= MAX_CREDIT.
- Accepted coin: credit += value next cycle; IDLE goes to COLLECT.
- Any other coin_valid (invalid code, overflow, same cycle as cancel/accepted buy, or in DISPENSE/CHANGE): coin_reject=1 on the next cycle only; credit unchanged.
- The credit + value sum is computed at CREDIT_W+1 bits, so no wrap-around.
- DISPENSE:
  - dispense held high until a cycle with dispense_ack=1.
  - In that ack cycle: dispense <= 0 and go to CHANGE if credit>0, else IDLE.
  - buy and cancel are ignored. dispense_ack outside DISPENSE is ignored.
- CHANGE:
  - Each cycle: change_pulse=1 and credit decrements by 1.
  - When credit reaches 0: change_pulse deasserts and state goes to IDLE.
  - A refund of N shillings gives exactly N consecutive change_pulse cycles, first pulse the cycle after entry.
- busy and the state transition register together; latency is one cycle from the accepted input to the output change.

Optional Feature:
GRUEL_VEND_AUDIT_EN
- Defined: adds output sales_count[15:0].
  - Increments by 1 on each dispense_ack accepted in DISPENSE.
  - Wraps 0xFFFF to 0; cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- After reset, insert coins 11 then 11 (4+4) then buy:
  - credit 4, then 8; gruel_ok=1.
  - dispense rises, credit=4; ack after 3 cycles.
  - Then 4 change_pulse cycles, credit=0, IDLE.
- Credit 7, insert coin 10 (2 shillings): coin_reject pulse, credit stays 7. Insert 01: credit=8.
- Credit 3, buy: ignored, dispense stays 0. Then coin_val=00: coin_reject pulse, credit stays 3.
- Credit 5, buy and cancel in the same cycle: cancel wins, exactly 5 change_pulses, no dispense.
- Credit 6, buy; in DISPENSE insert coin 01 (reject pulse); assert reset before ack: all outputs return to reset values next cycle.
- With GRUEL_VEND_AUDIT_EN defined: three complete purchases leave sales_count=3; a cancel-only refund leaves it unchanged.
